// File: rtl/eer_pkg.sv
// Shared definitions for the receive-side parser: word width, header type
// codes, packet lengths, parser state encoding and the saturating increment.
package eer_pkg;

    localparam int WORD_WIDTH = 16;

    localparam logic [3:0] TYPE_HB    = 4'h1;
    localparam logic [3:0] TYPE_CHADV = 4'h2;

    // Packet lengths in words, header included.
    localparam int HB_WORDS    = 2;
    localparam int CHADV_WORDS = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HB1,
        S_ADV1,
        S_ADV2,
        S_ADV3,
        S_EMIT_HB,
        S_EMIT_ADV,
        S_DROP
    } parser_state_t;

    // Unsigned +1 that sticks at all-ones instead of wrapping.
    function automatic logic [WORD_WIDTH-1:0] sat_inc(input logic [WORD_WIDTH-1:0] v);
        return (v == '1) ? v : v + WORD_WIDTH'(1);
    endfunction

    // Where a header word sends the parser.
    function automatic parser_state_t hdr_next_state(input logic [3:0] hdr_type);
        case (hdr_type)
            TYPE_HB:    return S_HB1;
            TYPE_CHADV: return S_ADV1;
            default:    return S_DROP;
        endcase
    endfunction

endpackage

// File: rtl/ch_adv_parser.sv
// Receive-side packet parser feeding the known-cluster-head selector.
// Splits the 16-bit receive stream into heartbeat (HB) and CH advertisement
// (CHADV) packets and emits one-cycle en_KCH / HB_reset pulses with fields.
// Optional feature: define CHADV_DROP_STATS_EN to add the drop_count port
// (unknown headers, truncated packets and self-advertisements).
module ch_adv_parser
    import eer_pkg::*;
(
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [WORD_WIDTH-1:0] my_nodeID,
    input  logic                  rx_valid,
    input  logic                  rx_sop,
    input  logic [WORD_WIDTH-1:0] rx_word,
    output logic                  rx_ready,
    output logic                  en_KCH,
    output logic [WORD_WIDTH-1:0] fCH_ID,
    output logic [WORD_WIDTH-1:0] fCH_Hops,
    output logic [WORD_WIDTH-1:0] fCH_QValue,
    output logic                  HB_reset,
    output logic [WORD_WIDTH-1:0] HB_CHlimit
`ifdef CHADV_DROP_STATS_EN
   ,output logic [WORD_WIDTH-1:0] drop_count
`endif
);

    parser_state_t state_q, state_d;

    // Scratch captures for the packet in flight; published only on completion
    // so the field buses never show a partial or rejected advertisement.
    logic [WORD_WIDTH-1:0] id_q, id_d;
    logic [WORD_WIDTH-1:0] hops_q, hops_d;

    logic [WORD_WIDTH-1:0] fch_id_q, fch_id_d;
    logic [WORD_WIDTH-1:0] fch_hops_q, fch_hops_d;
    logic [WORD_WIDTH-1:0] fch_qv_q, fch_qv_d;
    logic [WORD_WIDTH-1:0] hb_limit_q, hb_limit_d;

    logic       xfer;
    logic       hdr_xfer;
    logic       self_adv;
    logic [3:0] hdr_type;

    assign rx_ready = (state_q != S_EMIT_HB) && (state_q != S_EMIT_ADV);
    assign xfer     = rx_valid && rx_ready;
    assign hdr_xfer = xfer && rx_sop;
    assign hdr_type = rx_word[WORD_WIDTH-1 -: 4];
    assign self_adv = (id_q == my_nodeID);

    assign en_KCH     = (state_q == S_EMIT_ADV);
    assign HB_reset   = (state_q == S_EMIT_HB);
    assign fCH_ID     = fch_id_q;
    assign fCH_Hops   = fch_hops_q;
    assign fCH_QValue = fch_qv_q;
    assign HB_CHlimit = hb_limit_q;

    // Next-state and field capture; a header anywhere outside EMIT restarts parsing.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        id_d       = id_q;
        hops_d     = hops_q;
        fch_id_d   = fch_id_q;
        fch_hops_d = fch_hops_q;
        fch_qv_d   = fch_qv_q;
        hb_limit_d = hb_limit_q;

        case (state_q)
            S_IDLE, S_DROP: begin
                if (hdr_xfer) state_d = hdr_next_state(hdr_type);
            end
            S_HB1: begin
                if (hdr_xfer) begin
                    state_d = hdr_next_state(hdr_type);
                end else if (xfer) begin
                    hb_limit_d = rx_word;
                    state_d    = S_EMIT_HB;
                end
            end
            S_ADV1: begin
                if (hdr_xfer) begin
                    state_d = hdr_next_state(hdr_type);
                end else if (xfer) begin
                    id_d    = rx_word;
                    state_d = S_ADV2;
                end
            end
            S_ADV2: begin
                if (hdr_xfer) begin
                    state_d = hdr_next_state(hdr_type);
                end else if (xfer) begin
                    hops_d  = rx_word;
                    state_d = S_ADV3;
                end
            end
            S_ADV3: begin
                if (hdr_xfer) begin
                    state_d = hdr_next_state(hdr_type);
                end else if (xfer) begin
                    if (self_adv) begin
                        state_d = S_IDLE;
                    end else begin
                        fch_id_d   = id_q;
                        fch_hops_d = sat_inc(hops_q);
                        fch_qv_d   = rx_word;
                        state_d    = S_EMIT_ADV;
                    end
                end
            end
            S_EMIT_HB, S_EMIT_ADV: state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // State and field registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            hops_q     <= '0;
            fch_id_q   <= '0;
            fch_hops_q <= '1;
            fch_qv_q   <= '0;
            hb_limit_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            id_q       <= id_d;
            hops_q     <= hops_d;
            fch_id_q   <= fch_id_d;
            fch_hops_q <= fch_hops_d;
            fch_qv_q   <= fch_qv_d;
            hb_limit_q <= hb_limit_d;
        end
    end

`ifdef CHADV_DROP_STATS_EN
    logic [WORD_WIDTH-1:0] drop_q, drop_d;
    logic                  hdr_unknown;
    logic                  truncated;
    logic                  self_drop;

    // Drop events; a truncation by an unknown header counts as two drops.
    always_comb begin
        hdr_unknown = hdr_xfer && (hdr_type != TYPE_HB) && (hdr_type != TYPE_CHADV);
        truncated   = hdr_xfer && (state_q inside {S_HB1, S_ADV1, S_ADV2, S_ADV3});
        self_drop   = xfer && !rx_sop && (state_q == S_ADV3) && self_adv;
        drop_d      = drop_q;
        if (truncated)                drop_d = sat_inc(drop_d);
        if (hdr_unknown || self_drop) drop_d = sat_inc(drop_d);
    end

    // Saturating drop counter, cleared only by reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) drop_q <= '0;
        else       drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_ch_adv_parser.sv
// Self-checking bench for ch_adv_parser: directed packets from the test plan
// followed by randomized packet streams, compared every cycle against a
// packet-level reference model. drop_count is compared when
// CHADV_DROP_STATS_EN is defined.
module tb_ch_adv_parser;
    import eer_pkg::*;

    logic                  clk = 1'b0;
    logic                  nrst;
    logic [WORD_WIDTH-1:0] my_nodeID;
    logic                  rx_valid;
    logic                  rx_sop;
    logic [WORD_WIDTH-1:0] rx_word;
    logic                  rx_ready;
    logic                  en_KCH;
    logic [WORD_WIDTH-1:0] fCH_ID;
    logic [WORD_WIDTH-1:0] fCH_Hops;
    logic [WORD_WIDTH-1:0] fCH_QValue;
    logic                  HB_reset;
    logic [WORD_WIDTH-1:0] HB_CHlimit;
`ifdef CHADV_DROP_STATS_EN
    logic [WORD_WIDTH-1:0] drop_count;
`endif

    ch_adv_parser dut (
        .clk        (clk),
        .nrst       (nrst),
        .my_nodeID  (my_nodeID),
        .rx_valid   (rx_valid),
        .rx_sop     (rx_sop),
        .rx_word    (rx_word),
        .rx_ready   (rx_ready),
        .en_KCH     (en_KCH),
        .fCH_ID     (fCH_ID),
        .fCH_Hops   (fCH_Hops),
        .fCH_QValue (fCH_QValue),
        .HB_reset   (HB_reset),
        .HB_CHlimit (HB_CHlimit)
`ifdef CHADV_DROP_STATS_EN
       ,.drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                  sop;
        logic [WORD_WIDTH-1:0] word;
    } beat_t;

    beat_t stim_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    bit                    m_ready, m_en, m_hb;
    logic [WORD_WIDTH-1:0] m_id, m_hops, m_q, m_limit;
    int                    m_drop;
    logic [WORD_WIDTH-1:0] pkt[CHADV_WORDS];
    int                    pkt_len;
    bit                    pkt_known;
    logic [3:0]            pkt_type;
    int                    mdl_en_cnt = 0, mdl_hb_cnt = 0;
    int                    dut_en_cnt = 0, dut_hb_cnt = 0;
    int                    cyc = 0, last_en_cyc = -1, last_hb_cyc = -1;

    function automatic int words_of(input logic [3:0] t);
        return (t == TYPE_HB) ? HB_WORDS : CHADV_WORDS;
    endfunction

    task automatic model_reset();
        m_ready = 1; m_en = 0; m_hb = 0;
        m_id = '0; m_hops = 16'hFFFF; m_q = '0; m_limit = '0;
        m_drop = 0; pkt_len = 0; pkt_known = 0; pkt_type = '0;
    endtask

    task automatic bump_drop();
        if (m_drop < 65535) m_drop++;
    endtask

    task automatic model_accept(input beat_t b);
        if (b.sop) begin
            if (pkt_known && pkt_len > 0 && pkt_len < words_of(pkt_type)) bump_drop();
            pkt_type  = b.word[15:12];
            pkt_known = (pkt_type == TYPE_HB) || (pkt_type == TYPE_CHADV);
            if (!pkt_known) bump_drop();
            pkt[0]  = b.word;
            pkt_len = 1;
        end else if (pkt_known && pkt_len > 0 && pkt_len < words_of(pkt_type)) begin
            pkt[pkt_len] = b.word;
            pkt_len++;
            if (pkt_len == words_of(pkt_type)) begin
                if (pkt_type == TYPE_HB) begin
                    m_limit = pkt[1];
                    m_hb    = 1;
                    mdl_hb_cnt++;
                end else if (pkt[1] == my_nodeID) begin
                    bump_drop();
                end else begin
                    m_id   = pkt[1];
                    m_hops = (pkt[2] == 16'hFFFF) ? 16'hFFFF : pkt[2] + 16'd1;
                    m_q    = pkt[3];
                    m_en   = 1;
                    mdl_en_cnt++;
                end
                pkt_len = 0;
            end
        end
    endtask

    // One clock cycle: compare outputs, drive inputs, advance model at the edge.
    task automatic step(input bit full_rate);
        bit acc;
        check("rx_ready", rx_ready, m_ready);
        check("en_KCH", en_KCH, m_en);
        check("HB_reset", HB_reset, m_hb);
        check("fCH_ID", fCH_ID, m_id);
        check("fCH_Hops", fCH_Hops, m_hops);
        check("fCH_QValue", fCH_QValue, m_q);
        check("HB_CHlimit", HB_CHlimit, m_limit);
`ifdef CHADV_DROP_STATS_EN
        check("drop_count", drop_count, m_drop);
`endif
        if (en_KCH === 1'b1) begin dut_en_cnt++; last_en_cyc = cyc; end
        if (HB_reset === 1'b1) begin dut_hb_cnt++; last_hb_cyc = cyc; end

        if (stim_q.size() > 0 && (full_rate || $urandom_range(0, 3) != 0)) begin
            rx_valid = 1'b1;
            rx_sop   = stim_q[0].sop;
            rx_word  = stim_q[0].word;
        end else begin
            rx_valid = 1'b0;
            rx_sop   = 1'($urandom_range(0, 1));
            rx_word  = 16'($urandom);
        end

        @(posedge clk);
        acc  = rx_valid && m_ready;
        m_en = 0;
        m_hb = 0;
        if (acc) model_accept(stim_q.pop_front());
        m_ready = !(m_en || m_hb);
        cyc++;
        #1;
    endtask

    task automatic run(input bit full_rate);
        int budget = 20000;
        while (stim_q.size() > 0 && budget > 0) begin
            step(full_rate);
            budget--;
        end
        if (budget == 0) check("drain_timeout", 0, 1);
        repeat (3) step(full_rate);
    endtask

    task automatic push(input logic sop, input logic [WORD_WIDTH-1:0] w);
        beat_t b;
        b.sop  = sop;
        b.word = w;
        stim_q.push_back(b);
    endtask

    task automatic push_adv(input logic [15:0] id, input logic [15:0] hops, input logic [15:0] q);
        push(1, {TYPE_CHADV, 12'($urandom)});
        push(0, id);
        push(0, hops);
        push(0, q);
    endtask

    task automatic push_random_packet();
        int kind = $urandom_range(0, 9);
        logic [15:0] hops;
        case ($urandom_range(0, 3))
            0:       hops = 16'hFFFF;
            1:       hops = 16'hFFFE;
            2:       hops = 16'h0000;
            default: hops = 16'($urandom);
        endcase
        case (kind)
            0, 1, 2, 3: push_adv($urandom_range(0, 1) ? 16'($urandom_range(1, 8)) : 16'($urandom),
                                 hops, 16'($urandom));
            4, 5: begin
                push(1, {TYPE_HB, 12'($urandom)});
                push(0, 16'($urandom));
            end
            6: begin
                logic [3:0] t;
                t = 4'($urandom_range(3, 15));
                if ($urandom_range(0, 3) == 0) t = 4'h0;
                push(1, {t, 12'($urandom)});
                for (int i = 0; i < int'($urandom_range(0, 4)); i++) push(0, 16'($urandom));
            end
            7: begin
                if ($urandom_range(0, 1) != 0) begin
                    push(1, {TYPE_CHADV, 12'($urandom)});
                    for (int i = 0; i < int'($urandom_range(0, 2)); i++) push(0, 16'($urandom));
                end else begin
                    push(1, {TYPE_HB, 12'($urandom)});
                end
            end
            8: for (int i = 0; i < int'($urandom_range(1, 2)); i++) push(0, 16'($urandom));
            default: push_adv(my_nodeID, hops, 16'($urandom));
        endcase
    endtask

    initial begin
        int t0, en0, hb0, d0;
        nrst      = 1'b0;
        my_nodeID = 16'd3;
        rx_valid  = 1'b0;
        rx_sop    = 1'b0;
        rx_word   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", rx_ready, 1);
        check("rst_hops", fCH_Hops, 16'hFFFF);
        nrst = 1'b1;

        // Test 1: CHADV at full rate, pulse 4 cycles after header.
        t0 = cyc; en0 = dut_en_cnt;
        push(1, 16'h2000); push(0, 16'h0007); push(0, 16'h0002); push(0, 16'h0150);
        run(1);
        check("t1_pulses", dut_en_cnt - en0, 1);
        check("t1_latency", last_en_cyc - t0, 4);
        check("t1_id", fCH_ID, 16'h0007);
        check("t1_hops", fCH_Hops, 16'h0003);
        check("t1_q", fCH_QValue, 16'h0150);

        // Test 2: HB, pulse 2 cycles after header, limit held.
        t0 = cyc; hb0 = dut_hb_cnt;
        push(1, 16'h1000); push(0, 16'h0004);
        run(1);
        repeat (4) step(0);
        check("t2_pulses", dut_hb_cnt - hb0, 1);
        check("t2_latency", last_hb_cyc - t0, 2);
        check("t2_limit", HB_CHlimit, 16'h0004);

        // Test 3: saturating hops, then a self-advertisement.
        d0 = m_drop; en0 = dut_en_cnt;
        push_adv(16'h0009, 16'hFFFF, 16'h0010);
        run(1);
        check("t3_hops_sat", fCH_Hops, 16'hFFFF);
        push_adv(16'h0003, 16'h0001, 16'h0020);
        run(1);
        check("t3_pulses", dut_en_cnt - en0, 1);
        check("t3_self_drop", m_drop - d0, 1);

        // Test 4: truncated CHADV followed by an HB.
        en0 = dut_en_cnt; hb0 = dut_hb_cnt;
        push(1, 16'h2000); push(0, 16'h0005);
        push(1, 16'h1000); push(0, 16'h0021);
        run(1);
        check("t4_no_adv", dut_en_cnt - en0, 0);
        check("t4_hb", dut_hb_cnt - hb0, 1);
        check("t4_limit", HB_CHlimit, 16'h0021);

        // Test 5: unknown type with body words, then a normal CHADV.
        en0 = dut_en_cnt;
        push(1, 16'h5000); push(0, 16'h0001); push(0, 16'h0002); push(0, 16'h0003);
        push_adv(16'h000A, 16'h0000, 16'h0077);
        run(1);
        check("t5_pulses", dut_en_cnt - en0, 1);
        check("t5_id", fCH_ID, 16'h000A);
        check("t5_hops", fCH_Hops, 16'h0001);

        // Test 6: reset while in S_ADV2.
        push_adv(16'h000B, 16'h0001, 16'h0002);
        step(1);
        step(1);
        #1 nrst = 1'b0;
        #1;
        check("t6_ready", rx_ready, 1);
        check("t6_en", en_KCH, 0);
        check("t6_hb", HB_reset, 0);
        check("t6_id", fCH_ID, 0);
        check("t6_hops", fCH_Hops, 16'hFFFF);
        check("t6_q", fCH_QValue, 0);
        check("t6_limit", HB_CHlimit, 0);
`ifdef CHADV_DROP_STATS_EN
        check("t6_drop", drop_count, 0);
`endif
        stim_q.delete();
        model_reset();
        rx_valid = 1'b0;
        @(posedge clk);
        #1 nrst = 1'b1;
        en0 = dut_en_cnt;
        push_adv(16'h000C, 16'h0004, 16'h0099);
        run(1);
        check("t6_after", dut_en_cnt - en0, 1);
        check("t6_after_id", fCH_ID, 16'h000C);

        // Randomized packet stream with random valid gaps.
        for (int i = 0; i < 250; i++) push_random_packet();
        run(0);
        for (int i = 0; i < 100; i++) push_random_packet();
        run(1);

        check("total_en", dut_en_cnt, mdl_en_cnt);
        check("total_hb", dut_hb_cnt, mdl_hb_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ch_adv_parser.md
# ch_adv_parser

Receive-side packet parser that sits directly upstream of the known-cluster-head selector. It accepts a 16-bit word stream from the radio receive buffer, classifies each packet as heartbeat (HB) or cluster-head advertisement (CHADV), and extracts the fields. It then emits single-cycle `en_KCH` / `HB_reset` pulses with the matching field buses, which the selector consumes unmodified.

## Interface
- `WORD_WIDTH`, 16, stream and field word width
- `TYPE_HB`, 4'h1, header type code for heartbeat
- `TYPE_CHADV`, 4'h2, header type code for CH advertisement
- `clk` in 1: the block's single clock
- `nrst` in 1: reset, asynchronous and active-low
- `my_nodeID` in WORD_WIDTH: this node's ID; static while `nrst` is high
- `rx_valid` in 1: stream word valid
- `rx_sop` in 1: qualifies `rx_word` as a packet header; meaningful only with `rx_valid`
- `rx_word` in WORD_WIDTH: stream data
- `rx_ready` out 1: parser can accept a word; a transfer occurs when `rx_valid && rx_ready`
- `en_KCH` out 1: 1-cycle pulse, CHADV fields valid
- `fCH_ID` out WORD_WIDTH: advertised CH ID
- `fCH_Hops` out WORD_WIDTH: received hop count + 1, saturating
- `fCH_QValue` out WORD_WIDTH: advertised Q-value
- `HB_reset` out 1: 1-cycle pulse, new heartbeat round
- `HB_CHlimit` out WORD_WIDTH: CH limit from the last heartbeat, held
- `drop_count` out WORD_WIDTH: dropped-packet counter; present only with `CHADV_DROP_STATS_EN`

## Operation
- Header word: type = `rx_word[15:12]`; bits [11:0] are ignored.
- HB packet is 2 words: header, CH limit.
- CHADV packet is 4 words: header, CH_ID, hops, Q-value.
- States:
  - S_IDLE: a transfer with `rx_sop` decodes the type. HB → S_HB1; CHADV → S_ADV1; any other type → S_DROP. Words without `rx_sop` are discarded and stay in S_IDLE.
  - S_HB1: the next word is captured into `HB_CHlimit` → S_EMIT_HB.
  - S_ADV1 → S_ADV2 → S_ADV3 capture ID, hops and Q in turn. Leaving S_ADV3 goes to S_EMIT_ADV, unless captured ID == `my_nodeID`; that self-advertisement counts as a drop and goes to S_IDLE.
  - S_EMIT_HB / S_EMIT_ADV: `rx_ready` = 0; assert `HB_reset` or `en_KCH` for exactly this cycle → S_IDLE.
  - S_DROP: accept and discard words until a word with `rx_sop`, which is then decoded as in S_IDLE in the same cycle.
- `rx_ready` = 1 in every state except the two EMIT states.
- Truncation: a transfer with `rx_sop` in S_HB1/S_ADVx aborts the current packet. No pulse is emitted, the abort counts as a drop, and the new header is decoded in that same cycle.
- Hops arithmetic: `fCH_Hops` = received + 1, unsigned; 16'hFFFF stays 16'hFFFF.
- Field buses hold their last value outside pulses. `HB_CHlimit` changes only when an HB limit word is captured.
- Reset values: state S_IDLE, `rx_ready` 1, `en_KCH` 0, `HB_reset` 0, `fCH_ID` 0, `fCH_Hops` 16'hFFFF, `fCH_QValue` 0, `HB_CHlimit` 0, `drop_count` 0.
- Reset asserted mid-packet: the partial packet is discarded with no pulse and no drop count.

## Timing
- Last packet word transferred at edge N → pulse high from edge N to edge N+1; fields are stable during the pulse.
- Header-to-pulse latency: 2 cycles for HB and 4 cycles for CHADV, at full-rate `rx_valid`.
- `en_KCH` and `HB_reset` are never high in the same cycle.
- Back-to-back packets: the next header is accepted in the cycle after EMIT, giving a peak of one CHADV per 5 cycles.
- `rx_valid` gaps stall the FSM with no timeout.

## Configuration
- `CHADV_DROP_STATS_EN` defined:
  - `drop_count` port exists.
  - It increments by 1 per unknown-type header, truncated packet, or self-advertisement.
  - It saturates at 16'hFFFF and resets only on `nrst`.
- Not defined: the port and the counter logic are absent; parsing behaviour is identical.

## Structure
- Shared package `eer_pkg`:
  - type codes `TYPE_HB`/`TYPE_CHADV`
  - state enum `parser_state_t`
  - `WORD_WIDTH`
  - packet word-count constants
- No sub-module. The saturating increment is a package function used by both hops and `drop_count`.

## Test plan
- CHADV {0x2000, 0x0007, 0x0002, 0x0150} at full rate, `my_nodeID`=3 → one `en_KCH` pulse 4 cycles after header; ID 7, hops 3, Q 0x0150; `rx_ready` low that cycle.
- HB {0x1000, 0x0004} → `HB_reset` pulse 2 cycles after header; `HB_CHlimit`=4 and held afterward.
- CHADV with hops 0xFFFF → `fCH_Hops`=0xFFFF. CHADV with ID == `my_nodeID` → no pulse; `drop_count` +1.
- CHADV header plus 1 word, then new HB header with `rx_sop` → no `en_KCH`; HB still parsed correctly; `drop_count` +1.
- Header type 0x5 followed by 3 words, then valid CHADV → first packet ignored with `drop_count` +1; second emits normally.
- `nrst` pulsed low during S_ADV2 → all outputs return to reset values immediately; a following full CHADV parses normally.
